// File: rtl/tiny_riscv_periph_ctrl_pkg.sv
// Shared register map, status bit positions and drain FSM encoding for the
// tiny_riscv peripheral controller.
package tiny_riscv_periph_ctrl_pkg;

  // One-hot word-address bit per register; seg digits occupy REG_SEG0.. upward
  localparam int REG_LED       = 0;
  localparam int REG_UART_DATA = 1;
  localparam int REG_UART_STAT = 2;
  localparam int REG_SEG0      = 3;
  localparam int REG_TIMER     = 7;

  localparam int STAT_TX_IDLE  = 0;
  localparam int STAT_EMPTY    = 1;
  localparam int STAT_OVF      = 2;
  localparam int STAT_FULL     = 9;
  localparam int STAT_CNT_LSB  = 16;
  localparam int STAT_CNT_W    = 5;

  typedef enum logic {
    DRAIN_IDLE = 1'b0,
    DRAIN_BUSY = 1'b1
  } drain_state_t;

endpackage

// File: rtl/tiny_riscv_periph_ctrl_if.sv
// CPU-side load/store bus of the peripheral controller.
interface tiny_riscv_periph_ctrl_if;
  logic        sel;
  logic [7:0]  word_addr;
  logic [31:0] write_data;
  logic [3:0]  write_mask;
  logic        read_strobe;
  logic [31:0] read_data;
  logic        read_valid;

  modport master (
    output sel, word_addr, write_data, write_mask, read_strobe,
    input  read_data, read_valid
  );

  modport slave (
    input  sel, word_addr, write_data, write_mask, read_strobe,
    output read_data, read_valid
  );
endinterface

// File: rtl/tiny_riscv_sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted only when a pop
// frees an entry in the same cycle.
module tiny_riscv_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/tiny_riscv_periph_ctrl.sv
// Memory-mapped LED / 7-seg / switch / UART-TX controller for tiny_riscv.
// Define TINY_RISCV_PERIPH_TIMER_EN to add the free-running cycle timer at word-address bit 7.
module tiny_riscv_periph_ctrl
  import tiny_riscv_periph_ctrl_pkg::*;
#(
  parameter int NUM_LED       = 4,
  parameter int NUM_SW        = 4,
  parameter int NUM_SEG       = 2,
  parameter int TX_FIFO_DEPTH = 8
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  tiny_riscv_periph_ctrl_if.slave bus,
  input  logic [NUM_SW-1:0]      i_Switch,
  output logic [NUM_LED-1:0]     o_LED,
  output logic [7*NUM_SEG-1:0]   o_seg,
  output logic [7:0]             o_tx_byte,
  output logic                   o_tx_start,
  input  logic                   i_tx_done
);
  localparam int SW_BIT = REG_SEG0 + NUM_SEG;
  localparam int CNT_W  = $clog2(TX_FIFO_DEPTH) + 1;

  logic              wr_en;
  logic              rd_en;
  logic [6:0]        seg_q  [NUM_SEG];
  logic [6:0]        seg_rd [NUM_SEG+1];
  logic [NUM_SW-1:0] sw_meta;
  logic [NUM_SW-1:0] sw_sync;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [7:0]        fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic              tx_ovf;
  drain_state_t      state_q;
  drain_state_t      state_d;
  logic [31:0]       status;
  logic [31:0]       timer_q;
  logic [31:0]       rd_mux;
  logic              unused_bus;

  assign wr_en      = bus.sel & (|bus.write_mask);
  assign rd_en      = bus.sel & bus.read_strobe;
  assign fifo_push  = wr_en & bus.word_addr[REG_UART_DATA];
  assign unused_bus = ^{bus.write_data, bus.word_addr};

  always_ff @(posedge i_Clk) begin
    if (i_Rst)                               o_LED <= '0;
    else if (wr_en && bus.word_addr[REG_LED]) o_LED <= bus.write_data[NUM_LED-1:0];
  end

  // Each digit is its own register; seg_rd accumulates the read-side OR
  assign seg_rd[0] = '0;
  for (genvar k = 0; k < NUM_SEG; k++) begin : g_seg
    always_ff @(posedge i_Clk) begin
      if (i_Rst)                                    seg_q[k] <= '1;
      else if (wr_en && bus.word_addr[REG_SEG0+k])  seg_q[k] <= bus.write_data[6:0];
    end
    assign o_seg[7*k +: 7] = seg_q[k];
    assign seg_rd[k+1]     = seg_rd[k] | (bus.word_addr[REG_SEG0+k] ? seg_q[k] : 7'h00);
  end

  always_ff @(posedge i_Clk) begin
    sw_meta <= i_Switch;
    sw_sync <= sw_meta;
  end

  tiny_riscv_sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_tx_fifo (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .push    (fifo_push),
    .wr_data (bus.write_data[7:0]),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // A dropped byte outranks a simultaneous clear so the loss is never hidden
  always_ff @(posedge i_Clk) begin
    if (i_Rst)
      tx_ovf <= 1'b0;
    else if (fifo_push && fifo_full && !fifo_pop)
      tx_ovf <= 1'b1;
    else if (wr_en && bus.word_addr[REG_UART_STAT] && bus.write_data[STAT_OVF])
      tx_ovf <= 1'b0;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) state_q <= DRAIN_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    case (state_q)
      DRAIN_IDLE: if (!fifo_empty) begin
        fifo_pop = 1'b1;
        state_d  = DRAIN_BUSY;
      end
      DRAIN_BUSY: if (i_tx_done) state_d = DRAIN_IDLE;
      default:    state_d = DRAIN_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_tx_start <= 1'b0;
      o_tx_byte  <= 8'h00;
    end else begin
      o_tx_start <= fifo_pop;
      if (fifo_pop) o_tx_byte <= fifo_head;
    end
  end

  always_comb begin
    status                                = '0;
    status[STAT_TX_IDLE]                  = fifo_empty && (state_q == DRAIN_IDLE);
    status[STAT_EMPTY]                    = fifo_empty;
    status[STAT_OVF]                      = tx_ovf;
    status[STAT_FULL]                     = fifo_full;
    status[STAT_CNT_LSB +: STAT_CNT_W]    = STAT_CNT_W'(fifo_count);
  end

`ifdef TINY_RISCV_PERIPH_TIMER_EN
  always_ff @(posedge i_Clk) begin
    if (i_Rst)                                  timer_q <= 32'h0;
    else if (wr_en && bus.word_addr[REG_TIMER]) timer_q <= bus.write_data;
    else                                        timer_q <= timer_q + 32'd1;
  end
`else
  assign timer_q = 32'h0;
`endif

  always_comb begin
    rd_mux = '0;
    if (bus.word_addr[REG_LED])       rd_mux |= 32'(o_LED);
    if (bus.word_addr[REG_UART_STAT]) rd_mux |= status;
    if (bus.word_addr[SW_BIT])        rd_mux |= 32'(sw_sync);
    if (bus.word_addr[REG_TIMER])     rd_mux |= timer_q;
    rd_mux[6:0] = rd_mux[6:0] | seg_rd[NUM_SEG];
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      bus.read_valid <= 1'b0;
      bus.read_data  <= 32'h0;
    end else begin
      bus.read_valid <= rd_en;
      if (rd_en) bus.read_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_tiny_riscv_periph_ctrl.sv
// Directed bench for tiny_riscv_periph_ctrl (NUM_LED=4, NUM_SW=4, NUM_SEG=2, depth 8).
module tb_tiny_riscv_periph_ctrl;

  logic        i_Clk = 1'b0;
  logic        i_Rst;
  logic [3:0]  i_Switch;
  logic [3:0]  o_LED;
  logic [13:0] o_seg;
  logic [7:0]  o_tx_byte;
  logic        o_tx_start;
  logic        i_tx_done;
  int          checks = 0;
  int          errors = 0;

  always #5 i_Clk = ~i_Clk;

  tiny_riscv_periph_ctrl_if bus ();

  tiny_riscv_periph_ctrl #(
    .NUM_LED       (4),
    .NUM_SW        (4),
    .NUM_SEG       (2),
    .TX_FIFO_DEPTH (8)
  ) dut (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .bus        (bus),
    .i_Switch   (i_Switch),
    .o_LED      (o_LED),
    .o_seg      (o_seg),
    .o_tx_byte  (o_tx_byte),
    .o_tx_start (o_tx_start),
    .i_tx_done  (i_tx_done)
  );

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.sel         = 1'b0;
    bus.word_addr   = 8'h00;
    bus.write_data  = 32'h0;
    bus.write_mask  = 4'h0;
    bus.read_strobe = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus.sel        = 1'b1;
    bus.word_addr  = a;
    bus.write_data = d;
    bus.write_mask = 4'hF;
    tick();
    idle();
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    bus.sel         = 1'b1;
    bus.word_addr   = a;
    bus.read_strobe = 1'b1;
    tick();
    check("rd_valid", 32'(bus.read_valid), 32'h1);
    d = bus.read_data;
    idle();
  endtask

  task automatic done_pulse();
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic        seen;
    i_Rst     = 1'b1;
    i_Switch  = 4'h0;
    i_tx_done = 1'b0;
    idle();
    tick();
    tick();
    i_Rst = 1'b0;

    check("rst_led",    32'(o_LED),          32'h0);
    check("rst_seg",    32'(o_seg),          32'h3FFF);
    check("rst_start",  32'(o_tx_start),     32'h0);
    check("rst_byte",   32'(o_tx_byte),      32'h0);
    check("rst_rvalid", 32'(bus.read_valid), 32'h0);
    check("rst_rdata",  bus.read_data,       32'h0);

    // LED write, then the same write without sel
    wr(8'h01, 32'h5);
    check("led_write", 32'(o_LED), 32'h5);
    bus.sel = 1'b0; bus.word_addr = 8'h01; bus.write_data = 32'hA; bus.write_mask = 4'hF;
    tick();
    idle();
    check("led_nosel", 32'(o_LED), 32'h5);

    // Seg digit 0, then LED + digit 1 together
    wr(8'h08, 32'h12);
    wr(8'h11, 32'h33);
    check("seg_multi", 32'(o_seg), 32'h1992);
    check("led_multi", 32'(o_LED), 32'h3);
    rd(8'h09, d);
    check("rd_or", d, 32'h13);
    wr(8'h40, 32'hFF);
    rd(8'h40, d);
    check("rd_unmapped", d, 32'h0);
    check("led_unmapped", 32'(o_LED), 32'h3);

    bus.sel = 1'b0; bus.word_addr = 8'h01; bus.read_strobe = 1'b1;
    tick();
    idle();
    check("rvalid_nosel", 32'(bus.read_valid), 32'h0);

    // Switch read and its latency
    i_Switch = 4'hA;
    tick();
    tick();
    bus.sel = 1'b1; bus.word_addr = 8'h20; bus.read_strobe = 1'b1;
    check("sw_rvalid_pre", 32'(bus.read_valid), 32'h0);
    tick();
    check("sw_rvalid", 32'(bus.read_valid), 32'h1);
    check("sw_data",   bus.read_data,       32'hA);
    idle();
    tick();
    check("sw_rvalid_post", 32'(bus.read_valid), 32'h0);
    i_Switch = 4'h5;
    tick();
    bus.sel = 1'b1; bus.word_addr = 8'h20; bus.read_strobe = 1'b1;
    tick();
    check("sw_old", bus.read_data, 32'hA);
    tick();
    check("sw_new", bus.read_data, 32'h5);
    idle();

    // UART: 'A','B','C'
    wr(8'h02, 32'h41);
    wr(8'h02, 32'h42);
    check("tx_a_start", 32'(o_tx_start), 32'h1);
    check("tx_a_byte",  32'(o_tx_byte),  32'h41);
    wr(8'h02, 32'h43);
    check("tx_a_pulse", 32'(o_tx_start), 32'h0);
    rd(8'h04, d);
    check("stat_busy2", d, 32'h0002_0000);
    tick();
    check("tx_hold", 32'(o_tx_start), 32'h0);
    done_pulse();
    check("tx_b_gap", 32'(o_tx_start), 32'h0);
    tick();
    check("tx_b_start", 32'(o_tx_start), 32'h1);
    check("tx_b_byte",  32'(o_tx_byte),  32'h42);
    tick();
    check("tx_b_pulse", 32'(o_tx_start), 32'h0);
    done_pulse();
    check("tx_c_gap", 32'(o_tx_start), 32'h0);
    tick();
    check("tx_c_start", 32'(o_tx_start), 32'h1);
    check("tx_c_byte",  32'(o_tx_byte),  32'h43);
    done_pulse();
    rd(8'h04, d);
    check("stat_idle", d, 32'h3);
    done_pulse();
    check("done_idle_start", 32'(o_tx_start), 32'h0);
    rd(8'h04, d);
    check("stat_idle2", d, 32'h3);

    // Overflow: 0x10 goes in flight, then 9 more with the drain busy
    wr(8'h02, 32'h10);
    for (int i = 1; i <= 9; i++) wr(8'h02, 32'h10 + 32'(i));
    rd(8'h04, d);
    check("stat_ovf", d, 32'h0008_0204);
    wr(8'h04, 32'h4);
    rd(8'h04, d);
    check("stat_clr", d, 32'h0008_0200);
    wr(8'h06, 32'h04);
    rd(8'h04, d);
    check("stat_ovf_wins", d, 32'h0008_0204);
    wr(8'h04, 32'h4);
    done_pulse();
    wr(8'h02, 32'h55);
    check("full_pop_start", 32'(o_tx_start), 32'h1);
    check("full_pop_byte",  32'(o_tx_byte),  32'h11);
    rd(8'h04, d);
    check("stat_full_pop", d, 32'h0008_0200);

    // Reset with the drain busy and the FIFO full
    i_Rst = 1'b1;
    tick();
    i_Rst = 1'b0;
    check("rst2_seg",   32'(o_seg),      32'h3FFF);
    check("rst2_led",   32'(o_LED),      32'h0);
    check("rst2_start", 32'(o_tx_start), 32'h0);
    check("rst2_byte",  32'(o_tx_byte),  32'h0);
    rd(8'h04, d);
    check("rst2_stat", d, 32'h3);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (o_tx_start) seen = 1'b1;
    end
    check("rst2_no_start", 32'(seen), 32'h0);

`ifdef TINY_RISCV_PERIPH_TIMER_EN
    wr(8'h80, 32'hFFFF_FFFE);
    tick();
    bus.sel = 1'b1; bus.word_addr = 8'h80; bus.read_strobe = 1'b1;
    tick();
    check("timer_ff",   bus.read_data, 32'hFFFF_FFFF);
    tick();
    check("timer_wrap", bus.read_data, 32'h0000_0000);
    idle();
`else
    wr(8'h80, 32'h1234_5678);
    rd(8'h80, d);
    check("timer_off", d, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
